// File: rtl/led_pwm_driver.sv
// LED dimmer/blinker: a prescaled 8-bit PWM frame with a shadowed config,
// plus a frame counter that drives optional blinking.
module led_pwm_driver #(
  parameter int ANCHO = 32,
  parameter int PRESC = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] Entrada,
  input  logic             WE,
  input  logic [15:0]      led_in,
  output logic [ANCHO-1:0] Salida,
  output logic [15:0]      led_pad
);

  localparam logic [15:0] PMAX = 16'(PRESC - 1);
  localparam logic [ANCHO-1:0] CFG_RST = ANCHO'(8'hFF);

  logic [ANCHO-1:0] cfg_q, cfg_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic [7:0]       pwm_q, pwm_d;
  logic [7:0]       duty_q, duty_d;
  logic             ben_q, ben_d;
  logic [3:0]       sel_q, sel_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic [15:0]      pad_q, pad_d;

  logic tick;
  logic frame_end;
  logic pwm_on;
  logic blank;

  always_comb begin
    tick      = (pcnt_q == PMAX);
    frame_end = tick && (pwm_q == 8'hFF);

    cfg_d = cfg_q;
    if (WE) cfg_d = {{(ANCHO-13){1'b0}}, Entrada[12:0]};

    pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    pwm_d  = tick ? pwm_q + 8'd1 : pwm_q;

    // Shadows sample the pre-write cfg so a frame never sees a torn config
    duty_d = duty_q;
    ben_d  = ben_q;
    sel_d  = sel_q;
    if (frame_end) begin
      duty_d = cfg_q[7:0];
      ben_d  = cfg_q[8];
      sel_d  = cfg_q[12:9];
    end

    fcnt_d = fcnt_q;
    if (WE)             fcnt_d = 16'd0;
    else if (frame_end) fcnt_d = fcnt_q + 16'd1;

    if (duty_q == 8'hFF)      pwm_on = 1'b1;
    else if (duty_q == 8'h00) pwm_on = 1'b0;
    else                      pwm_on = (pwm_q < duty_q);

    blank = ben_q & fcnt_q[sel_q];
    pad_d = led_in & {16{pwm_on & ~blank}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q  <= CFG_RST;
      pcnt_q <= 16'd0;
      pwm_q  <= 8'd0;
      duty_q <= 8'hFF;
      ben_q  <= 1'b0;
      sel_q  <= 4'd0;
      fcnt_q <= 16'd0;
      pad_q  <= 16'd0;
    end else begin
      cfg_q  <= cfg_d;
      pcnt_q <= pcnt_d;
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
      ben_q  <= ben_d;
      sel_q  <= sel_d;
      fcnt_q <= fcnt_d;
      pad_q  <= pad_d;
    end
  end

  assign Salida  = cfg_q;
  assign led_pad = pad_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: directed scenarios plus random traffic,
// checked each cycle against a time-indexed reference model.
module tb_led_pwm_driver;

  localparam int PR = 2;
  localparam int FR = PR * 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [31:0] ent = 32'd0;
  logic [15:0] led_in = 16'd0;
  logic [31:0] salida;
  logic [15:0] led_pad;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: phase is derived from cycles elapsed since reset release
  int          t;
  logic [31:0] m_cfg;
  int          m_duty;
  bit          m_ben;
  int          m_sel;
  logic [15:0] m_fcnt;
  logic [15:0] m_led;

  led_pwm_driver #(.ANCHO(32), .PRESC(PR)) dut (
    .clk     (clk),
    .rst     (rst),
    .Entrada (ent),
    .WE      (we),
    .led_in  (led_in),
    .Salida  (salida),
    .led_pad (led_pad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    t      = 0;
    m_cfg  = 32'hFF;
    m_duty = 255;
    m_ben  = 0;
    m_sel  = 0;
    m_fcnt = 16'd0;
    m_led  = 16'd0;
  endtask

  task automatic model_edge();
    int pwm;
    bit fe;
    bit on;
    bit blank;
    pwm = (t / PR) % 256;
    fe  = (t % FR) == FR - 1;
    if (m_duty == 255)    on = 1;
    else if (m_duty == 0) on = 0;
    else                  on = pwm < m_duty;
    blank = m_ben && m_fcnt[m_sel];
    m_led = (on && !blank) ? led_in : 16'd0;
    if (fe) begin
      m_duty = int'(m_cfg[7:0]);
      m_ben  = m_cfg[8];
      m_sel  = int'(m_cfg[12:9]);
    end
    if (we)      m_fcnt = 16'd0;
    else if (fe) m_fcnt = m_fcnt + 16'd1;
    if (we) m_cfg = ent & 32'h1FFF;
    t++;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check("led_pad", {16'd0, led_pad}, {16'd0, m_led});
    check("salida", salida, m_cfg);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic cfg_write(input logic [31:0] v);
    we  = 1'b1;
    ent = v;
    step();
    we  = 1'b0;
    ent = $urandom;
  endtask

  initial begin
    model_reset();
    led_in = 16'hA5A5;
    run(3);
    rst = 1'b0;
    run(600);

    led_in = 16'hFFFF;
    cfg_write(32'h80);
    run(1500);

    cfg_write(32'h00);
    run(600);
    cfg_write(32'hFF);
    run(600);

    led_in = 16'h3C5A;
    cfg_write(32'h1FF);
    run(2500);

    cfg_write(32'hFF);
    run(600);
    // Write landing exactly on the frame-end edge
    while ((t % FR) != FR - 1) step();
    cfg_write(32'h40);
    run(1200);

    // Asynchronous reset in the middle of a frame
    run(100);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_pad", {16'd0, led_pad}, 32'd0);
    check("async_salida", salida, 32'hFF);
    run(3);
    rst = 1'b0;
    led_in = 16'hA5A5;
    run(600);

    repeat (15000) begin
      led_in = 16'($urandom);
      if ($urandom_range(299) == 0)
        cfg_write(($urandom_range(1) == 0) ? ($urandom & 32'h3FF) : $urandom);
      else
        step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 SHALL have parameter ANCHO, default 32, bus data width of the config port.
REQ-002 SHALL have parameter PRESC, default 100, clocks per PWM step (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Entrada  input  ANCHO  config write data from processor bus.
REQ-006 SHALL have port WE  input  1  config write enable, one write per cycle high.
REQ-007 SHALL have port led_in  input  16  LED pattern from the memory-mapped LED register.
REQ-008 SHALL have port Salida  output  ANCHO  config register readback.
REQ-009 SHALL have port led_pad  output  16  registered, dimmed/blinked LED pin drive.

Function
REQ-010 SHALL hold config register cfg: [7:0] duty, [8] blink_en, [12:9] blink_sel, [ANCHO-1:13] reserved.
REQ-011 SHALL load cfg from Entrada on a clk edge with WE=1; reserved bits stored as 0.
REQ-012 SHALL drive Salida = cfg combinationally; write visible on Salida the cycle after the WE edge.
REQ-013 SHALL run prescaler pcnt 0..PRESC-1, wrap to 0; tick=1 in the cycle pcnt==PRESC-1.
REQ-014 SHALL advance 8-bit pwm_cnt by 1 on each tick, wrapping 255->0; the wrap tick is frame_end.
REQ-015 SHALL keep shadow duty/blink_en/blink_sel, loaded from cfg only on frame_end (value of cfg before any same-cycle write).
REQ-016 SHALL compute pwm_on = 1 if shadow duty==255, 0 if duty==0, else (pwm_cnt < duty).
REQ-017 SHALL keep 16-bit frame counter fcnt, +1 on frame_end, wrap 0xFFFF->0.
REQ-018 SHALL clear fcnt to 0 on any cycle with WE=1 (write priority over frame_end increment).
REQ-019 SHALL compute blank = shadow blink_en AND fcnt[shadow blink_sel].
REQ-020 SHALL register led_pad <= led_in AND {16{pwm_on AND NOT blank}}; latency 1 clock from led_in/state.
REQ-021 SHALL not reset pcnt or pwm_cnt on config writes; phase is free-running.
REQ-022 SHALL treat PRESC==1 as tick every cycle.

Reset
REQ-023 SHALL, on rst=1 asynchronously: cfg=0x000000FF (duty 255, blink off), shadows = same, pcnt=0, pwm_cnt=0, fcnt=0, led_pad=0.
REQ-024 SHALL, with rst high, hold all state; first tick PRESC cycles after rst deasserts.
REQ-025 SHALL, with reset values, give led_pad = led_in delayed one clock (full brightness).
REQ-026 SHALL abort any frame on rst mid-operation; no partial-frame state survives.

Verification (PRESC=2)
REQ-027 Reset, led_in=0xA5A5, no writes -> led_pad 0 during rst, then 0xA5A5 from first edge after release, constant.
REQ-028 Write cfg=0x80, led_in=0xFFFF -> old duty until next frame_end; then led_pad=0xFFFF for pwm_cnt 0..127 (256 clk), 0x0000 for 128..255 (256 clk), repeating.
REQ-029 Write cfg=0x00 -> after next frame_end led_pad=0 permanently; write 0xFF -> after next frame_end led_pad=led_in continuously.
REQ-030 Write cfg=0x1FF (blink_en, sel 0, duty 255) -> after next frame_end, led_pad toggles between led_in and 0 every 512 clk; Salida=0x1FF.
REQ-031 WE coincident with frame_end (cfg 0xFF->0x40) -> frame just starting uses duty 255; duty 0x40 applies from following frame; fcnt=0 after that edge.
REQ-032 rst asserted mid-frame with cfg=0x40 -> led_pad=0 immediately, Salida=0xFF, after release full-on behaviour as REQ-027.
